// File: rtl/traffic_pkg.sv
// Shared types and constants for the junction signal phase scheduler.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_CLEAR = 2'd0,
    PH_GREEN = 2'd1,
    PH_AMBER = 2'd2
  } phase_e;

  // Per-board light pattern {Red, Orange, LeftG, FrontG, RightG}
  localparam logic [4:0] LT_RED   = 5'b10000;
  localparam logic [4:0] LT_AMBER = 5'b01000;
  localparam logic [4:0] LT_GREEN = 5'b00111;

  localparam logic [1:0] BRD_B = 2'd0;
  localparam logic [1:0] BRD_L = 2'd1;
  localparam logic [1:0] BRD_F = 2'd2;
  localparam logic [1:0] BRD_R = 2'd3;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] r;
    if (v[0]) begin
      r = BRD_B;
    end else if (v[1]) begin
      r = BRD_L;
    end else if (v[2]) begin
      r = BRD_F;
    end else begin
      r = BRD_R;
    end
    return r;
  endfunction

endpackage

// File: rtl/next_board_sel.sv
// Picks the board for the next green: emergency, then priority, then round-robin.
module next_board_sel
  import traffic_pkg::*;
(
  input  logic [3:0] emer_req,
  input  logic [3:0] pri_req,
  input  logic [1:0] rr_ptr,
  output logic [1:0] sel,
  output logic       sel_emer,
  output logic       sel_rr
);

  // Fixed-priority arbitration between request classes
  always_comb begin
    sel      = rr_ptr;
    sel_emer = 1'b0;
    sel_rr   = 1'b0;
    if (|emer_req) begin
      sel      = lowest_set(emer_req);
      sel_emer = 1'b1;
    end else if (|pri_req) begin
      sel      = lowest_set(pri_req);
    end else begin
      sel      = rr_ptr;
      sel_rr   = 1'b1;
    end
  end

endmodule

// File: rtl/signal_phase_scheduler.sv
// GREEN -> AMBER -> CLEAR sequencer for four junction boards.
// Optional EMER_PREEMPT_EN: an emergency on another board cuts green short once MIN_GREEN ticks elapsed.
module signal_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_T   = 16,
  parameter int AMBER_T   = 4,
  parameter int CLEAR_T   = 2,
  parameter int MIN_GREEN = 4,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [3:0]       pri_req,
  input  logic [3:0]       emer_req,
  output logic [19:0]      lights,
  output logic [1:0]       cur_board,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remain,
  output logic             emer_active,
  output logic             served
);

`ifdef EMER_PREEMPT_EN
  localparam bit PREEMPT_EN = 1'b1;
`else
  localparam bit PREEMPT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] GREEN_LD = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] AMBER_LD = CNT_W'(AMBER_T);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_T);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  // remain at or below this means the coming tick completes MIN_GREEN ticks of green
  localparam logic [CNT_W-1:0] PREEMPT_REM = CNT_W'(GREEN_T - MIN_GREEN + 1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [1:0]       cur_board_q, cur_board_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic             emer_active_q, emer_active_d;
  logic             served_q, served_d;
  logic [19:0]      lights_q, lights_d;

  logic [1:0]       sel_s;
  logic             sel_emer_s, sel_rr_s, preempt_s;
  logic [3:0]       other_emer_s;

  next_board_sel u_sel (
    .emer_req (emer_req),
    .pri_req  (pri_req),
    .rr_ptr   (rr_ptr_q),
    .sel      (sel_s),
    .sel_emer (sel_emer_s),
    .sel_rr   (sel_rr_s)
  );

  assign other_emer_s = emer_req & ~(4'b0001 << cur_board_q);
  assign preempt_s    = PREEMPT_EN && (|other_emer_s) && (remain_q <= PREEMPT_REM);

  // Phase FSM and countdown; everything except served waits for tick
  always_comb begin
    phase_d       = phase_q;
    remain_d      = remain_q;
    cur_board_d   = cur_board_q;
    rr_ptr_d      = rr_ptr_q;
    emer_active_d = emer_active_q;
    served_d      = 1'b0;
    if (tick) begin
      case (phase_q)
        PH_CLEAR: begin
          if (remain_q == ONE) begin
            phase_d       = PH_GREEN;
            remain_d      = GREEN_LD;
            cur_board_d   = sel_s;
            emer_active_d = sel_emer_s;
            served_d      = 1'b1;
            rr_ptr_d      = sel_rr_s ? (rr_ptr_q + 2'd1) : rr_ptr_q;
          end else begin
            remain_d = remain_q - ONE;
          end
        end
        PH_GREEN: begin
          if (remain_q == ONE) begin
            if (emer_req[cur_board_q]) begin
              emer_active_d = 1'b1;
            end else begin
              phase_d  = PH_AMBER;
              remain_d = AMBER_LD;
            end
          end else if (preempt_s) begin
            phase_d  = PH_AMBER;
            remain_d = AMBER_LD;
          end else begin
            remain_d = remain_q - ONE;
          end
        end
        PH_AMBER: begin
          if (remain_q == ONE) begin
            phase_d  = PH_CLEAR;
            remain_d = CLEAR_LD;
          end else begin
            remain_d = remain_q - ONE;
          end
        end
        default: begin
          phase_d  = PH_CLEAR;
          remain_d = CLEAR_LD;
        end
      endcase
    end else begin
      phase_d = phase_q;
    end
  end

  // Light decode from the next state so lights stay registered
  always_comb begin
    lights_d = {4{LT_RED}};
    for (int n = 0; n < 4; n++) begin
      if (cur_board_d == 2'(n) && phase_d == PH_GREEN) begin
        lights_d[5*n +: 5] = LT_GREEN;
      end else if (cur_board_d == 2'(n) && phase_d == PH_AMBER) begin
        lights_d[5*n +: 5] = LT_AMBER;
      end else begin
        lights_d[5*n +: 5] = LT_RED;
      end
    end
  end

  // State registers with synchronous reset to an all-red clearance
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= PH_CLEAR;
      remain_q      <= CLEAR_LD;
      cur_board_q   <= BRD_B;
      rr_ptr_q      <= BRD_B;
      emer_active_q <= 1'b0;
      served_q      <= 1'b0;
      lights_q      <= {4{LT_RED}};
    end else begin
      phase_q       <= phase_d;
      remain_q      <= remain_d;
      cur_board_q   <= cur_board_d;
      rr_ptr_q      <= rr_ptr_d;
      emer_active_q <= emer_active_d;
      served_q      <= served_d;
      lights_q      <= lights_d;
    end
  end

  assign lights      = lights_q;
  assign cur_board   = cur_board_q;
  assign phase       = phase_q;
  assign remain      = remain_q;
  assign emer_active = emer_active_q;
  assign served      = served_q;

endmodule
